// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - receive-side decoder for a multiplexed seven-segment bus
//
// Watches the seven_segment_data / seven_segment_enable bus, waits until the
// bus has been stable for SETTLE_CYCLES clocks with exactly one digit
// selected, then decodes the segment pattern back to BCD into a 4-digit
// shadow of the display.
//
// Parameters:
//   SETTLE_CYCLES  - clocks the bus must be unchanged before capture (1..255)
//   SEG_ACTIVE_LOW - 1: segment/dp bits are active-low (common anode)
//   EN_ACTIVE_LOW  - 1: digit enable bits are active-low
//
// Ports:
//   clk                  - system clock, rising edge
//   reset                - asynchronous active-low reset
//   seven_segment_data   - {dp, g, f, e, d, c, b, a}
//   seven_segment_enable - digit select, bit i = digit i
//   clear_errors         - one-cycle clear of the sticky error flags
//   digit_value          - {d3, d2, d1, d0} BCD shadow
//   digit_dp             - last captured dp per digit
//   digit_blank          - 1 = last capture for that digit was all segments off
//   capture_valid        - one-cycle strobe per capture
//   capture_idx          - digit index of the current capture
//   capture_digit        - decoded value of the current capture, 4'hF if blank/bad
//   bad_pattern          - sticky: non-BCD, non-blank pattern captured
//   enable_error         - sticky: multi-hot enable held stable
//   glitch_count         - (only with SEG_READER_GLITCH_CNT_EN) saturating count of
//                          settle windows abandoned because the bus changed
//
// Optional feature macro: SEG_READER_GLITCH_CNT_EN

module seven_segment_reader #(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seven_segment_data,
  input  logic [3:0]  seven_segment_enable,
  input  logic        clear_errors,
  output logic [15:0] digit_value,
  output logic [3:0]  digit_dp,
  output logic [3:0]  digit_blank,
  output logic        capture_valid,
  output logic [1:0]  capture_idx,
  output logic [3:0]  capture_digit,
  output logic        bad_pattern,
  output logic        enable_error
`ifdef SEG_READER_GLITCH_CNT_EN
  ,
  output logic [7:0]  glitch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  localparam logic [7:0] LP_SETTLE    = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LP_SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  // Normalised bus: 1 = segment lit / digit selected
  logic [7:0]  w_data;
  logic [3:0]  w_en;
  logic [11:0] w_in;

  assign w_data = SEG_ACTIVE_LOW ? ~seven_segment_data : seven_segment_data;
  assign w_en   = EN_ACTIVE_LOW ? ~seven_segment_enable : seven_segment_enable;
  assign w_in   = {w_en, w_data};

  logic [11:0] r_in;
  logic [7:0]  r_cnt;
  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_digit_value;
  logic [3:0]  r_digit_dp;
  logic [3:0]  r_digit_blank;
  logic        r_capture_valid;
  logic [1:0]  r_capture_idx;
  logic [3:0]  r_capture_digit;
  logic        r_bad_pattern;
  logic        r_enable_error;

  logic        w_change;
  logic        w_en_onehot;
  logic        w_stable_done;
  logic        w_multi_err;
  logic        w_capture;
  logic        w_glitch;
  logic [3:0]  w_dec_val;
  logic        w_dec_ok;
  logic        w_blank;
  logic        w_bad;
  logic [1:0]  w_idx;

  assign w_change    = (w_in != r_in);
  assign w_en_onehot = $onehot(w_en);

  // True on exactly one cycle per stable period: the counter saturates at
  // SETTLE_CYCLES so it passes SETTLE_CYCLES-1 only once.
  assign w_stable_done = !w_change && (r_cnt == LP_SETTLE_M1);
  assign w_multi_err   = w_stable_done && !$onehot0(r_in[11:8]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in    <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else begin
      r_in    <= w_in;
      r_state <= w_state_nxt;
      if (w_change) begin
        r_cnt <= '0;
      end else if (r_cnt != LP_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // In SETTLE the registered enable is always one-hot, so capture needs no
  // extra enable check here.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_glitch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_en_onehot) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_change) begin
          w_glitch    = 1'b1;
          w_state_nxt = w_en_onehot ? S_SETTLE : S_IDLE;
        end else if (r_cnt == LP_SETTLE_M1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (w_change) w_state_nxt = w_en_onehot ? S_SETTLE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_dec_val = 4'hF;
    w_dec_ok  = 1'b1;
    case (r_in[6:0])
      7'h3F:   w_dec_val = 4'd0;
      7'h06:   w_dec_val = 4'd1;
      7'h5B:   w_dec_val = 4'd2;
      7'h4F:   w_dec_val = 4'd3;
      7'h66:   w_dec_val = 4'd4;
      7'h6D:   w_dec_val = 4'd5;
      7'h7D:   w_dec_val = 4'd6;
      7'h07:   w_dec_val = 4'd7;
      7'h7F:   w_dec_val = 4'd8;
      7'h6F:   w_dec_val = 4'd9;
      default: w_dec_ok  = 1'b0;
    endcase
  end

  assign w_blank = (r_in[6:0] == 7'h00);
  assign w_bad   = !w_dec_ok && !w_blank;

  always_comb begin
    w_idx = 2'd0;
    case (r_in[11:8])
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit_value   <= '0;
      r_digit_dp      <= '0;
      r_digit_blank   <= 4'hF;
      r_capture_valid <= 1'b0;
      r_capture_idx   <= '0;
      r_capture_digit <= '0;
      r_bad_pattern   <= 1'b0;
      r_enable_error  <= 1'b0;
    end else begin
      r_capture_valid <= w_capture;
      if (w_capture) begin
        r_capture_idx        <= w_idx;
        r_capture_digit      <= w_dec_val;
        r_digit_dp[w_idx]    <= r_in[7];
        r_digit_blank[w_idx] <= w_blank;
        if (w_dec_ok) r_digit_value[{w_idx, 2'b00} +: 4] <= w_dec_val;
      end
      // Set beats clear when both happen on the same cycle
      r_bad_pattern  <= (r_bad_pattern && !clear_errors) || (w_capture && w_bad);
      r_enable_error <= (r_enable_error && !clear_errors) || w_multi_err;
    end
  end

`ifdef SEG_READER_GLITCH_CNT_EN
  logic [7:0] r_glitch_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_glitch_count <= '0;
    end else if (clear_errors) begin
      r_glitch_count <= w_glitch ? 8'd1 : 8'd0;
    end else if (w_glitch && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'd1;
    end
  end

  assign glitch_count = r_glitch_count;
`endif

  assign digit_value   = r_digit_value;
  assign digit_dp      = r_digit_dp;
  assign digit_blank   = r_digit_blank;
  assign capture_valid = r_capture_valid;
  assign capture_idx   = r_capture_idx;
  assign capture_digit = r_capture_digit;
  assign bad_pattern   = r_bad_pattern;
  assign enable_error  = r_enable_error;

endmodule
